iic_slave_regs: RTL and testbench
=================================

# iic_slave_regs

I2C target (responder) with a byte-wide register file, answering a single 7-bit device address. It is the bus-side counterpart of the team's `iic_master`. It serves as a stand-in for an external I2C peripheral (RTC or I/O expander) in FPGA loopback and simulation benches, and as a configuration port for on-chip logic. The master's write/read transactions land in the register file. The local host reads and writes the same registers through a simple parallel port.

## Interface
Parameters:
- `DEV_ADDR`, default 7'h38: device address the target answers.
- `NREG`, default 16: register count. Must be a power of 2, 2..256. The pointer is log2(NREG) bits.
- `FILTER`, default 3: consecutive equal samples needed to accept a new SCL/SDA level.

Ports:
- `clk`  input  1: single system clock.
- `rst`  input  1: reset, synchronous and active-high.
- `scl_i`  input  1: SCL pad input. The target never drives SCL; there is no clock stretching.
- `sda_i`  input  1: SDA pad input.
- `sda_o`  output  1: SDA pad output, constant 0 (open-drain).
- `sda_t`  output  1: SDA tristate. 1 = released, 0 = pull low.
- `host_we`  input  1: host write strobe.
- `host_addr`  input  8: host register index, modulo NREG.
- `host_wdata`  input  8: host write data.
- `host_rdata`  output  8: registered read of reg[host_addr], 1-cycle latency.
- `wr_stb`  output  1: 1-cycle pulse per bus data byte written.
- `wr_addr`  output  8: register index of that write.
- `wr_data`  output  8: byte written.
- `busy`  output  1: high from a START matching DEV_ADDR until STOP, NACK or mismatch.

## Operation
- **Input conditioning.** scl_i and sda_i each pass through a 2-FF synchronizer and then a FILTER-sample debounce, giving `scl_f` and `sda_f`. Edges are detected on `scl_f` and `sda_f`.
- **Bus conditions.**
  - START: sda_f falls while scl_f is high.
  - STOP: sda_f rises while scl_f is high.
  - Both are recognized in every state and take priority over bit handling.
- **Bit timing.**
  - Bits are sampled on the scl_f rising edge.
  - The target changes sda_t only in the cycle after a scl_f falling edge.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
  - IDLE: sda_t=1; waits for START.
  - START (including repeated START) → ADDR. The bit counter clears; the pointer is kept.
  - ADDR: shift in 8 bits, MSB first. On the 8th rising edge:
    - bits[7:1] == DEV_ADDR → ADDR_ACK, latch the R/W bit, assert busy.
    - Otherwise → IDLE with sda_t held at 1.
  - ADDR_ACK: pull SDA low on the falling edge after bit 8 and release it on the next falling edge.
    - W → PTR.
    - R → RDATA. The shift register loads reg[ptr] at this point.
  - PTR: the received byte sets ptr = byte mod NREG → PTR_ACK (ACK as above) → WDATA.
  - WDATA: the received byte is written to reg[ptr] and wr_stb pulses with wr_addr=ptr, wr_data=byte. Then ptr increments, wrapping modulo NREG → WDATA_ACK → WDATA.
  - RDATA: drive the shift register MSB first (bit=0 → sda_t=0, bit=1 → sda_t=1). After 8 bits, release SDA and increment ptr → RDATA_ACK.
  - RDATA_ACK: sample SDA on the 9th rising edge.
    - Low (ACK) → RDATA, reloading reg[ptr] on the falling edge.
    - High (NACK) → IDLE with SDA released.
  - STOP in any state → IDLE, sda_t=1, busy=0. A partially received byte is discarded and no wr_stb is issued.
- **Register file.**
  - A host write and a bus write to the same index in the same cycle: the bus write wins.
  - A host write to the register currently being shifted out does not affect the byte in flight.
- **Reset values:**
  - sda_o=0, sda_t=1.
  - wr_stb=0, wr_addr=0, wr_data=0.
  - busy=0, host_rdata=0.
  - ptr=0, all registers 0.
  - State IDLE.

## Timing
- Pad-to-internal latency: 2 + FILTER clk cycles.
- SDA drive change: FILTER + 3 clk cycles after the SCL fall at the pad.
- Required clk frequency ≥ 4 × (FILTER + 3) × f_SCL. For example, 100 MHz with the master at DIV=500 meets this.
- wr_stb is asserted 1 cycle after the 8th data-bit rising edge is detected.
- host_rdata: 1-cycle latency from host_addr; it reflects a write made in the previous cycle.
- Glitches shorter than FILTER cycles on either line are ignored.
- rst asserted mid-transfer: sda_t=1 on the next cycle; the block returns to IDLE and waits for a new START.

## Test plan
- **Single write.** START, 0x70, 0x01, 0xC0, STOP → ACK on all three 9th clocks; exactly one wr_stb with wr_addr=0x01, wr_data=0xC0; host read of address 1 returns 0xC0.
- **Address mismatch.** START, 0x40, 0x55 → sda_t stays 1 for the whole frame; no wr_stb; busy stays 0.
- **Write with wrap** (NREG=16). Pointer 0x0F, then data 0xAA, 0xBB → reg15=0xAA, reg0=0xBB; wr_addr sequence 15, 0.
- **Read with repeated START.** Preload reg3=0x5A and reg4=0xA5 via the host port. Send W 0x70 with pointer 0x03, Sr, 0x71, master ACK then NACK → bytes 0x5A, 0xA5 on SDA; SDA released after the NACK; busy returns to 0.
- **Aborts and glitches.**
  - STOP after 4 bits of a data byte → no wr_stb; state IDLE.
  - A 1-cycle SCL low pulse mid-bit (FILTER=3) → bit count unchanged.
- **Reset while driving.** Assert rst while the target holds SDA low during an ACK → sda_t=1 the next cycle; every output at its reset value; the next valid transaction completes normally.

Source files
------------

// File: rtl/iic_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : iic_slave_regs
// Description : I2C target answering one 7-bit address, backed by a byte-wide
//               register file that is also reachable from a parallel host port.
// Revision    : 1.0 - initial release
// ============================================================================
module iic_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h38,
    parameter int         NREG     = 16,
    parameter int         FILTER   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int PW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int CW = $clog2(FILTER + 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8
    } state_t;

    // Line index 0 is SCL, index 1 is SDA.
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_filt;
    logic [1:0]    r_filt_d;
    logic [CW-1:0] r_fcnt [2];

    state_t        r_state;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [PW-1:0] r_ptr;
    logic          r_rw;
    logic          r_ackph;
    logic          r_sda_t;
    logic          r_busy;
    logic          r_wr_stb;
    logic [7:0]    r_wr_addr;
    logic [7:0]    r_wr_data;
    logic [7:0]    r_regs [NREG];
    logic [7:0]    r_host_rdata;

    logic          w_scl, w_scl_d, w_sda, w_sda_d;
    logic          w_rise, w_fall, w_start, w_stop;
    logic          w_last;
    logic [7:0]    w_byte;
    logic [7:0]    w_cur;
    logic [PW-1:0] w_host_idx;
    logic          w_bus_we;

    assign w_scl   = r_filt[0];
    assign w_sda   = r_filt[1];
    assign w_scl_d = r_filt_d[0];
    assign w_sda_d = r_filt_d[1];

    assign w_rise  = w_scl & ~w_scl_d;
    assign w_fall  = ~w_scl & w_scl_d;
    // Bus conditions require SCL high on both samples so an SDA change that
    // coincides with an SCL edge is never mistaken for START/STOP.
    assign w_start = w_scl & w_scl_d & w_sda_d & ~w_sda;
    assign w_stop  = w_scl & w_scl_d & ~w_sda_d & w_sda;

    assign w_last     = (r_bitcnt == 4'd7);
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_cur      = r_regs[r_ptr];
    assign w_host_idx = PW'(host_addr & 8'(NREG - 1));
    assign w_bus_we   = (r_state == S_WDATA) & w_rise & w_last & ~w_start & ~w_stop;

    assign sda_o      = 1'b0;
    assign sda_t      = r_sda_t;
    assign busy       = r_busy;
    assign wr_stb     = r_wr_stb;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign host_rdata = r_host_rdata;

    // Two-flop synchronizer followed by a FILTER-sample debounce per line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else begin
            r_sync1  <= {sda_i, scl_i};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == CW'(FILTER - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + CW'(1);
                end
            end
        end
    end

    // Register file: host write first so a same-index bus write overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_host_rdata <= '0;
        end else begin
            if (host_we) begin
                r_regs[w_host_idx] <= host_wdata;
            end
            if (w_bus_we) begin
                r_regs[r_ptr] <= w_byte;
            end
            r_host_rdata <= r_regs[w_host_idx];
        end
    end

    // Protocol FSM: bits sampled on SCL rise, SDA drive updated on SCL fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_ackph   <= 1'b0;
            r_sda_t   <= 1'b1;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_start) begin
                // Pointer deliberately kept so a repeated START can read back.
                r_state  <= S_ADDR;
                r_bitcnt <= '0;
                r_ackph  <= 1'b0;
                r_sda_t  <= 1'b1;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_bitcnt <= '0;
                r_ackph  <= 1'b0;
                r_sda_t  <= 1'b1;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_sda_t <= 1'b1;
                    end

                    S_ADDR, S_PTR, S_WDATA: begin
                        if (w_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last) begin
                                r_bitcnt <= '0;
                                r_ackph  <= 1'b0;
                                case (r_state)
                                    S_ADDR: begin
                                        if (w_byte[7:1] == DEV_ADDR) begin
                                            r_rw    <= w_byte[0];
                                            r_busy  <= 1'b1;
                                            r_state <= S_ADDR_ACK;
                                        end else begin
                                            r_busy  <= 1'b0;
                                            r_state <= S_IDLE;
                                        end
                                    end
                                    S_PTR: begin
                                        r_ptr   <= w_byte[PW-1:0];
                                        r_state <= S_PTR_ACK;
                                    end
                                    default: begin
                                        r_wr_stb  <= 1'b1;
                                        r_wr_addr <= 8'(r_ptr);
                                        r_wr_data <= w_byte;
                                        r_ptr     <= r_ptr + PW'(1);
                                        r_state   <= S_WDATA_ACK;
                                    end
                                endcase
                            end
                        end
                    end

                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        // First fall: pull low for the 9th clock; second fall: release.
                        if (w_fall) begin
                            if (!r_ackph) begin
                                r_sda_t <= 1'b0;
                                r_ackph <= 1'b1;
                            end else begin
                                r_ackph  <= 1'b0;
                                r_bitcnt <= '0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_state <= S_RDATA;
                                    r_sda_t <= w_cur[7];
                                    r_shift <= {w_cur[6:0], 1'b0};
                                end else begin
                                    r_sda_t <= 1'b1;
                                    r_state <= (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                                end
                            end
                        end
                    end

                    S_RDATA: begin
                        if (w_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_t  <= 1'b1;
                                r_ptr    <= r_ptr + PW'(1);
                                r_bitcnt <= '0;
                                r_state  <= S_RDATA_ACK;
                            end else begin
                                r_sda_t <= r_shift[7];
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end

                    S_RDATA_ACK: begin
                        // r_bitcnt marks that the master's ACK bit has been sampled.
                        if (w_rise) begin
                            if (w_sda) begin
                                r_sda_t <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_bitcnt <= 4'd1;
                            end
                        end else if (w_fall && r_bitcnt == 4'd1) begin
                            r_bitcnt <= '0;
                            r_state  <= S_RDATA;
                            r_sda_t  <= w_cur[7];
                            r_shift  <= {w_cur[6:0], 1'b0};
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_sda_t <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iic_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_iic_slave_regs
// Description : Self-checking bench for iic_slave_regs: host-port vector table
//               plus bit-banged I2C master sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iic_slave_regs;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_wdata = 8'h00;
    logic       sda_o, sda_t, wr_stb, busy;
    logic [7:0] host_rdata, wr_addr, wr_data;
    logic       sda_line;

    assign sda_line = sda_m & (sda_t | sda_o);

    iic_slave_regs #(
        .DEV_ADDR (7'h38),
        .NREG     (16),
        .FILTER   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_o      (sda_o),
        .sda_t      (sda_t),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Observers sampled on the falling clk edge.
    int         stb_cnt  = 0;
    int         low_cnt  = 0;
    int         busy_cnt = 0;
    logic [7:0] stb_addr_q[$];
    logic [7:0] stb_data_q[$];

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_cnt++;
            stb_addr_q.push_back(wr_addr);
            stb_data_q.push_back(wr_data);
        end
        if (sda_t === 1'b0) low_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
        qwait();
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        sda_m = b; qwait();
        scl_m = 1'b1;
        if (glitch) begin
            qwait();
            scl_m = 1'b0;
            @(posedge clk); #1;
            scl_m = 1'b1;
            qwait();
        end else begin
            qwait(); qwait();
        end
        scl_m = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        b = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == gbit);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~mack, 1'b0);
    endtask

    task automatic host_read(input logic [7:0] a, output logic [7:0] d);
        host_we   = 1'b0;
        host_addr = a;
        @(posedge clk); #1;
        d = host_rdata;
    endtask

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } hvec_t;

    hvec_t hv [10];

    initial begin
        logic       ack, ack2, ack3, b;
        logic [7:0] d, d2;
        int         sb, lb, bb, qb;

        hv[0] = '{1'b0, 8'h05, 8'h00, 8'h00};
        hv[1] = '{1'b1, 8'h05, 8'h3C, 8'h00};
        hv[2] = '{1'b0, 8'h05, 8'h00, 8'h3C};
        hv[3] = '{1'b1, 8'h15, 8'h81, 8'h3C};
        hv[4] = '{1'b0, 8'h05, 8'h00, 8'h81};
        hv[5] = '{1'b1, 8'h03, 8'h5A, 8'h00};
        hv[6] = '{1'b1, 8'h04, 8'hA5, 8'h00};
        hv[7] = '{1'b0, 8'h23, 8'h00, 8'h5A};
        hv[8] = '{1'b0, 8'h04, 8'h00, 8'hA5};
        hv[9] = '{1'b0, 8'h0F, 8'h00, 8'h00};

        // Reset state
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_sda_o",   sda_o, 0);
        check("rst_sda_t",   sda_t, 1);
        check("rst_wr_stb",  wr_stb, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy",    busy, 0);
        check("rst_rdata",   host_rdata, 0);

        // Host port vectors (also preloads reg3/reg4 for the read test)
        for (int i = 0; i < 10; i++) begin
            host_we    = hv[i].we;
            host_addr  = hv[i].addr;
            host_wdata = hv[i].wdata;
            @(posedge clk); #1;
            check($sformatf("host_vec%0d", i), host_rdata, hv[i].exp_rdata);
        end
        host_we = 1'b0;

        // Single write
        sb = stb_cnt; qb = stb_addr_q.size();
        i2c_start();
        write_byte(8'h70, -1, ack);
        check("wr_addr_ack", ack, 1);
        check("wr_busy_mid", busy, 1);
        write_byte(8'h01, -1, ack2);
        check("wr_ptr_ack", ack2, 1);
        write_byte(8'hC0, -1, ack3);
        check("wr_data_ack", ack3, 1);
        i2c_stop();
        check("wr_stb_count", stb_cnt - sb, 1);
        check("wr_stb_addr", stb_addr_q[qb], 8'h01);
        check("wr_stb_data", stb_data_q[qb], 8'hC0);
        check("wr_busy_end", busy, 0);
        host_read(8'h01, d);
        check("wr_host_read", d, 8'hC0);

        // Address mismatch
        sb = stb_cnt; lb = low_cnt; bb = busy_cnt;
        i2c_start();
        write_byte(8'h40, -1, ack);
        check("mm_addr_nack", ack, 0);
        write_byte(8'h55, -1, ack);
        check("mm_data_nack", ack, 0);
        i2c_stop();
        check("mm_sda_low_cycles", low_cnt - lb, 0);
        check("mm_stb_count", stb_cnt - sb, 0);
        check("mm_busy_cycles", busy_cnt - bb, 0);

        // Write with pointer wrap
        sb = stb_cnt; qb = stb_addr_q.size();
        i2c_start();
        write_byte(8'h70, -1, ack);
        write_byte(8'h0F, -1, ack);
        write_byte(8'hAA, -1, ack);
        write_byte(8'hBB, -1, ack2);
        check("wrap_last_ack", ack & ack2, 1);
        i2c_stop();
        check("wrap_stb_count", stb_cnt - sb, 2);
        check("wrap_addr0", stb_addr_q[qb], 8'h0F);
        check("wrap_addr1", stb_addr_q[qb+1], 8'h00);
        host_read(8'h0F, d);
        check("wrap_reg15", d, 8'hAA);
        host_read(8'h00, d);
        check("wrap_reg0", d, 8'hBB);

        // Read with repeated START
        i2c_start();
        write_byte(8'h70, -1, ack);
        write_byte(8'h03, -1, ack2);
        check("rd_setup_ack", ack & ack2, 1);
        i2c_start();
        write_byte(8'h71, -1, ack);
        check("rd_addr_ack", ack, 1);
        read_byte(d, 1'b1);
        read_byte(d2, 1'b0);
        check("rd_byte0", d, 8'h5A);
        check("rd_byte1", d2, 8'hA5);
        check("rd_sda_released", sda_t, 1);
        check("rd_busy_after_nack", busy, 0);
        i2c_stop();

        // Abort: STOP after 4 data bits
        sb = stb_cnt;
        i2c_start();
        write_byte(8'h70, -1, ack);
        write_byte(8'h02, -1, ack);
        write_bit(1'b1, 1'b0);
        write_bit(1'b0, 1'b0);
        write_bit(1'b1, 1'b0);
        write_bit(1'b1, 1'b0);
        i2c_stop();
        check("abort_stb_count", stb_cnt - sb, 0);
        check("abort_busy", busy, 0);
        host_read(8'h02, d);
        check("abort_reg2", d, 8'h00);

        // 1-cycle SCL low glitch inside a data bit
        sb = stb_cnt; qb = stb_addr_q.size();
        i2c_start();
        write_byte(8'h70, -1, ack);
        write_byte(8'h06, -1, ack);
        write_byte(8'h3C, 4, ack2);
        check("glitch_ack", ack2, 1);
        i2c_stop();
        check("glitch_stb_count", stb_cnt - sb, 1);
        check("glitch_wr_data", stb_data_q[qb], 8'h3C);
        host_read(8'h06, d);
        check("glitch_reg6", d, 8'h3C);

        // Reset while the target holds SDA low for an ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(((8'h70 >> i) & 8'h01) != 0, 1'b0);
        sda_m = 1'b1;
        qwait();
        check("rstd_ack_driving", sda_t, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstd_sda_t", sda_t, 1);
        check("rstd_sda_o", sda_o, 0);
        check("rstd_busy", busy, 0);
        check("rstd_wr_stb", wr_stb, 0);
        check("rstd_wr_addr", wr_addr, 0);
        check("rstd_wr_data", wr_data, 0);
        check("rstd_rdata", host_rdata, 0);
        rst = 1'b0;
        qwait();
        sb = stb_cnt; qb = stb_addr_q.size();
        i2c_start();
        write_byte(8'h70, -1, ack);
        write_byte(8'h07, -1, ack2);
        write_byte(8'h99, -1, ack3);
        check("post_rst_acks", {ack, ack2, ack3}, 3'b111);
        i2c_stop();
        check("post_rst_stb_count", stb_cnt - sb, 1);
        check("post_rst_wr_addr", stb_addr_q[qb], 8'h07);
        host_read(8'h07, d);
        check("post_rst_reg7", d, 8'h99);
        host_read(8'h0F, d);
        check("post_rst_reg15_cleared", d, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
